// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared widths and coefficient type for the NTT butterfly
package ntt_pkg;

  localparam int LOG_WIDTH  = 16;
  localparam int PARAM_RLOG = 18;

  typedef logic [LOG_WIDTH-1:0] coeff_t;

endpackage

// File: rtl/mod_addsub.sv
// rtl/mod_addsub.sv - modular add and subtract of two fully reduced residues
module mod_addsub
  import ntt_pkg::*;
#(
  parameter int W = LOG_WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] q,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  logic [W:0]   sum_full;
  logic [W:0]   sum_red;
  logic [W:0]   diff_full;
  logic [W-1:0] diff_wrap;

  // sum keeps its carry bit so x+y >= q is detected without truncation;
  // a borrow on x-y is repaired by adding q back (result always < q)
  always_comb begin
    sum_full  = {1'b0, x} + {1'b0, y};
    sum_red   = sum_full - {1'b0, q};
    diff_full = {1'b0, x} - {1'b0, y};
    diff_wrap = diff_full[W-1:0] + q;
    sum       = (sum_full >= {1'b0, q}) ? sum_red[W-1:0] : sum_full[W-1:0];
    diff      = diff_full[W] ? diff_wrap : diff_full[W-1:0];
  end

endmodule

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - 3-stage CT butterfly with Montgomery twiddle product; NTT_BFU_GS_EN adds GS mode
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int PARAM_RLOG = ntt_pkg::PARAM_RLOG,
  parameter int LOG_WIDTH  = ntt_pkg::LOG_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LOG_WIDTH-1:0]  modulus,
  input  logic [PARAM_RLOG-1:0] param_MinQinvModR,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LOG_WIDTH-1:0]  a_i,
  input  logic [LOG_WIDTH-1:0]  b_i,
  input  logic [LOG_WIDTH-1:0]  w_i,
`ifdef NTT_BFU_GS_EN
  input  logic                  mode_i,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LOG_WIDTH-1:0]  a_o,
  output logic [LOG_WIDTH-1:0]  b_o
);

  localparam int PW = 2 * LOG_WIDTH;
  localparam int AW = PARAM_RLOG + LOG_WIDTH + 1;

  // one enable for every stage: the whole pipe advances or freezes together
  logic advance;
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  // S1: operand register (x carries a or a+b, y carries b or a-b)
  logic                 s1_valid;
  logic [LOG_WIDTH-1:0] s1_x;
  logic [LOG_WIDTH-1:0] s1_y;
  logic [LOG_WIDTH-1:0] s1_w;
  logic [LOG_WIDTH-1:0] s1_x_d;
  logic [LOG_WIDTH-1:0] s1_y_d;

`ifdef NTT_BFU_GS_EN
  logic                 s1_mode;
  logic                 s2_mode;
  logic [LOG_WIDTH-1:0] pre_sum;
  logic [LOG_WIDTH-1:0] pre_diff;

  mod_addsub #(.W(LOG_WIDTH)) u_pre (
    .x    (a_i),
    .y    (b_i),
    .q    (modulus),
    .sum  (pre_sum),
    .diff (pre_diff)
  );

  // GS folds the add/sub into the first stage so latency stays at three
  always_comb begin
    s1_x_d = mode_i ? pre_sum  : a_i;
    s1_y_d = mode_i ? pre_diff : b_i;
  end
`else
  // CT only: operands go straight into the first stage
  always_comb begin
    s1_x_d = a_i;
    s1_y_d = b_i;
  end
`endif

  // S1 register; bubbles enter as cleared valid bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_w     <= '0;
`ifdef NTT_BFU_GS_EN
      s1_mode  <= 1'b0;
`endif
    end else if (advance) begin
      s1_valid <= in_valid_i;
      s1_x     <= s1_x_d;
      s1_y     <= s1_y_d;
      s1_w     <= w_i;
`ifdef NTT_BFU_GS_EN
      s1_mode  <= mode_i;
`endif
    end
  end

  // S2: Montgomery product t = y*w*R^-1 mod q
  logic [PW-1:0]         prod;
  logic [PARAM_RLOG-1:0] mont_u;
  logic [AW-1:0]         mont_acc;
  logic [LOG_WIDTH:0]    mont_s;
  logic [LOG_WIDTH:0]    mont_s_red;
  logic [LOG_WIDTH-1:0]  mont_t;

  // full-width accumulator: y*w + u*q is exactly divisible by R and < 2q*R
  always_comb begin
    prod       = {{LOG_WIDTH{1'b0}}, s1_y} * {{LOG_WIDTH{1'b0}}, s1_w};
    mont_u     = prod[PARAM_RLOG-1:0] * param_MinQinvModR;
    mont_acc   = {{(AW-PW){1'b0}}, prod}
               + ({{(LOG_WIDTH+1){1'b0}}, mont_u} * {{(PARAM_RLOG+1){1'b0}}, modulus});
    mont_s     = (LOG_WIDTH+1)'(mont_acc >> PARAM_RLOG);
    mont_s_red = mont_s - {1'b0, modulus};
    mont_t     = (mont_s >= {1'b0, modulus}) ? mont_s_red[LOG_WIDTH-1:0]
                                             : mont_s[LOG_WIDTH-1:0];
  end

  logic                 s2_valid;
  logic [LOG_WIDTH-1:0] s2_x;
  logic [LOG_WIDTH-1:0] s2_t;

  // S2 register: reduced product plus the pass-through operand
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_t     <= '0;
`ifdef NTT_BFU_GS_EN
      s2_mode  <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_x     <= s1_x;
      s2_t     <= mont_t;
`ifdef NTT_BFU_GS_EN
      s2_mode  <= s1_mode;
`endif
    end
  end

  // S3: CT add/sub of the pass-through operand and the product
  logic [LOG_WIDTH-1:0] post_sum;
  logic [LOG_WIDTH-1:0] post_diff;
  logic [LOG_WIDTH-1:0] res_a;
  logic [LOG_WIDTH-1:0] res_b;

  mod_addsub #(.W(LOG_WIDTH)) u_post (
    .x    (s2_x),
    .y    (s2_t),
    .q    (modulus),
    .sum  (post_sum),
    .diff (post_diff)
  );

`ifdef NTT_BFU_GS_EN
  // GS results are already formed: sum from S1, product from S2
  always_comb begin
    res_a = s2_mode ? s2_x : post_sum;
    res_b = s2_mode ? s2_t : post_diff;
  end
`else
  // CT results straight from the add/sub
  always_comb begin
    res_a = post_sum;
    res_b = post_diff;
  end
`endif

  // output register: data only loads with a valid triple, holds during stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
    end else if (advance) begin
      out_valid_o <= s2_valid;
      if (s2_valid) begin
        a_o <= res_a;
        b_o <= res_b;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// tb/tb_ntt_butterfly.sv - directed and randomized checks of ntt_butterfly (q = 12289, R = 2^18)
module tb_ntt_butterfly;

  localparam int Q     = 12289;
  localparam int MONT1 = 4075;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] modulus;
  logic [17:0] minq;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in, b_in, w_in;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out, b_out;

  int n_checks = 0;
  int n_fail   = 0;
  int rinv;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ntt_butterfly dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .modulus           (modulus),
    .param_MinQinvModR (minq),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .a_i               (a_in),
    .b_i               (b_in),
    .w_i               (w_in),
`ifdef NTT_BFU_GS_EN
    .mode_i            (mode),
`endif
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .a_o               (a_out),
    .b_o               (b_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // reference butterfly in plain modular arithmetic (R^-1 found by search)
  function automatic logic [31:0] model(input int a, input int b, input int w, input bit m);
    int s, d, t;
    if (m) begin
      s = (a + b) % Q;
      d = (a + Q - b) % Q;
      t = (((d * w) % Q) * rinv) % Q;
      return {16'(s), 16'(t)};
    end
    t = (((b * w) % Q) * rinv) % Q;
    return {16'((a + t) % Q), 16'((a + Q - t) % Q)};
  endfunction

  task automatic single(input string tag, input int a, input int b, input int w,
                        input bit m, input int ea, input int eb);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a_in = 16'(a); b_in = 16'(b); w_in = 16'(w); mode = m; out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, n, 3);
    check_eq({tag, "_a"}, {16'd0, a_out}, ea);
    check_eq({tag, "_b"}, {16'd0, b_out}, eb);
  endtask

  function automatic int pick(input bit rnd, input int k, input int mul, input int off);
    int r;
    if (!rnd) return (k * mul + off) % Q;
    r = int'($urandom_range(7));
    if (r == 0) return Q - 1;
    if (r == 1) return 0;
    return int'($urandom_range(Q - 1));
  endfunction

  // streams n triples; rnd selects random data/backpressure, else the fixed stall pattern
  task automatic run_stream(input string tag, input int n, input bit rnd);
    int  sent, got, cyc;
    bit  pend;
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    exp_q.delete();
    while (got < n && cyc < n * 8 + 100) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < n && (!rnd || $urandom_range(3) != 0)) begin
          in_valid = 1'b1;
          a_in = 16'(pick(rnd, sent, 1537, 11));
          b_in = 16'(pick(rnd, sent, 4099, 3));
          w_in = 16'((!rnd && sent == 0) ? MONT1 : pick(rnd, sent, 977, 5));
`ifdef NTT_BFU_GS_EN
          mode = rnd ? 1'($urandom_range(1)) : 1'(sent % 2);
`else
          mode = 1'b0;
`endif
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rnd ? ($urandom_range(9) < 7) : !(cyc >= 4 && cyc <= 6);
      #1;
      if (!rnd && cyc >= 4 && cyc <= 6) check_eq({tag, "_stall_in_ready"}, {31'd0, in_ready}, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_spurious_out"}, {31'd0, out_valid}, 0);
        end else begin
          check_eq({tag, "_out_a"}, {16'd0, a_out}, {16'd0, exp_q[0][31:16]});
          check_eq({tag, "_out_b"}, {16'd0, b_out}, {16'd0, exp_q[0][15:0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_in, b_in, w_in, mode));
        sent++;
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_count"}, got, n);
    repeat (4) @(negedge clk);
    check_eq({tag, "_drained"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint x;
    int     seen;
    modulus = 16'(Q);
    x = Q;
    repeat (4) x = (x * (2 - Q * x)) & 64'h3FFFF;
    minq = 18'((-x) & 64'h3FFFF);
    rinv = 0;
    for (int i = 1; i < Q; i++) if ((i * MONT1) % Q == 1) rinv = i;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; mode = 1'b0;
    a_in = 16'd1; b_in = 16'd2; w_in = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_a_o", {16'd0, a_out}, 0);
    check_eq("rst_b_o", {16'd0, b_out}, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 1);
    check_eq("post_rst_out_valid", {31'd0, out_valid}, 0);

    single("ct_basic", 100, 200, MONT1, 1'b0, 300, 12189);
    single("ct_max", 12288, 12288, MONT1, 1'b0, 12287, 0);
    single("ct_w0", 7, 9, 0, 1'b0, 7, 7);
`ifdef NTT_BFU_GS_EN
    single("gs_basic", 5, 10, MONT1, 1'b1, 15, 12284);
`endif

    run_stream("stall", 8, 1'b0);

    // reset with three triples in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0;
      a_in = 16'(k + 1); b_in = 16'(k + 2); w_in = 16'(MONT1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("midrst_stale", seen, 0);

    run_stream("rand", 10000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
